// File: rtl/id_ex_pipe.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_pipe
// Purpose  : ID/EX pipeline register of the 5-stage MIPS core. Carries the
//            decoder controls, register-file operands, immediate, PC+4 and
//            register-field indices into EX. Detects load-use hazards
//            (stalls PC and IF/ID, inserts a bubble into EX), honours a
//            branch flush from MEM, and keeps a saturating bubble count.
// Ports    : clk_i/rst_i         clock, async active-low reset
//            instr_i             IF/ID instruction word
//            pc_plus4_i, rs_data_i, rt_data_i, imm_i   ID datapath values
//            RegWrite_i..ALU_op_i                      decoder controls
//            flush_i             branch taken in MEM, kill ID instruction
//            *_o                 registered EX-stage copies
//            valid_o             EX holds a real (non-bubble, non-nop) instr
//            stall_o             combinational hold request for PC and IF/ID
//            bubble_cnt_o        saturating count of load-use bubbles
// Revision : 1.0  initial release
// ============================================================================
module id_ex_pipe #(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [31:0]   instr_i,
  input  logic [DW-1:0] pc_plus4_i,
  input  logic [DW-1:0] rs_data_i,
  input  logic [DW-1:0] rt_data_i,
  input  logic [DW-1:0] imm_i,
  input  logic          RegWrite_i,
  input  logic          ALUSrc_i,
  input  logic          RegDst_i,
  input  logic          Branch_i,
  input  logic          MemRead_i,
  input  logic          MemWrite_i,
  input  logic          MemtoReg_i,
  input  logic [1:0]    ALU_op_i,
  input  logic          flush_i,
  output logic          RegWrite_o,
  output logic          ALUSrc_o,
  output logic          RegDst_o,
  output logic          Branch_o,
  output logic          MemRead_o,
  output logic          MemWrite_o,
  output logic          MemtoReg_o,
  output logic [1:0]    ALU_op_o,
  output logic [DW-1:0] pc_plus4_o,
  output logic [DW-1:0] rs_data_o,
  output logic [DW-1:0] rt_data_o,
  output logic [DW-1:0] imm_o,
  output logic [4:0]    rs_o,
  output logic [4:0]    rt_o,
  output logic [4:0]    rd_o,
  output logic [5:0]    funct_o,
  output logic          valid_o,
  output logic          stall_o,
  output logic [CW-1:0] bubble_cnt_o
);

  localparam logic [5:0] c_OP_RTYPE = 6'd0;
  localparam logic [5:0] c_OP_BEQ   = 6'd4;
  localparam logic [5:0] c_OP_SW    = 6'd43;

  // Control bundle: {RegWrite, ALUSrc, RegDst, Branch, MemRead, MemWrite,
  //                  MemtoReg, ALU_op[1:0]}
  logic [8:0]    r_ctl;
  logic [DW-1:0] r_pc_plus4;
  logic [DW-1:0] r_rs_data;
  logic [DW-1:0] r_rt_data;
  logic [DW-1:0] r_imm;
  logic [4:0]    r_rs;
  logic [4:0]    r_rt;
  logic [4:0]    r_rd;
  logic [5:0]    r_funct;
  logic          r_valid;
  logic [CW-1:0] r_bubble_cnt;

  logic [8:0]    w_ctl_in;
  logic [5:0]    w_op;
  logic [4:0]    w_id_rs;
  logic [4:0]    w_id_rt;
  logic          w_uses_rt;
  logic          w_hazard;
  logic          w_stall;
  logic          w_kill;

  assign w_ctl_in = {RegWrite_i, ALUSrc_i, RegDst_i, Branch_i, MemRead_i,
                     MemWrite_i, MemtoReg_i, ALU_op_i};

  assign w_op    = instr_i[31:26];
  assign w_id_rs = instr_i[25:21];
  assign w_id_rt = instr_i[20:16];

  // Only R-type, beq and sw read rt as a source; for I-type ALU ops and
  // loads the rt field is a destination and must not trigger a stall.
  assign w_uses_rt = (w_op == c_OP_RTYPE) || (w_op == c_OP_BEQ) ||
                     (w_op == c_OP_SW);

  assign w_hazard = r_ctl[4] && (r_rt != 5'd0) && (instr_i != 32'd0) &&
                    ((r_rt == w_id_rs) || (w_uses_rt && (r_rt == w_id_rt)));

  // A flush already kills the ID instruction, so stalling it would be moot.
  assign w_stall = w_hazard && !flush_i;
  assign w_kill  = flush_i || w_stall;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ctl        <= '0;
      r_pc_plus4   <= '0;
      r_rs_data    <= '0;
      r_rt_data    <= '0;
      r_imm        <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_rd         <= '0;
      r_funct      <= '0;
      r_valid      <= 1'b0;
      r_bubble_cnt <= '0;
    end else begin
      // Data and indices are captured unconditionally so a bubble still
      // carries deterministic (if unused) payload.
      r_pc_plus4 <= pc_plus4_i;
      r_rs_data  <= rs_data_i;
      r_rt_data  <= rt_data_i;
      r_imm      <= imm_i;
      r_rs       <= w_id_rs;
      r_rt       <= w_id_rt;
      r_rd       <= instr_i[15:11];
      r_funct    <= instr_i[5:0];

      if (w_kill) begin
        r_ctl   <= '0;
        r_valid <= 1'b0;
      end else begin
        r_ctl   <= w_ctl_in;
        r_valid <= (instr_i != 32'd0);
      end

      if (w_stall && (r_bubble_cnt != {CW{1'b1}})) begin
        r_bubble_cnt <= r_bubble_cnt + CW'(1);
      end
    end
  end

  assign RegWrite_o   = r_ctl[8];
  assign ALUSrc_o     = r_ctl[7];
  assign RegDst_o     = r_ctl[6];
  assign Branch_o     = r_ctl[5];
  assign MemRead_o    = r_ctl[4];
  assign MemWrite_o   = r_ctl[3];
  assign MemtoReg_o   = r_ctl[2];
  assign ALU_op_o     = r_ctl[1:0];
  assign pc_plus4_o   = r_pc_plus4;
  assign rs_data_o    = r_rs_data;
  assign rt_data_o    = r_rt_data;
  assign imm_o        = r_imm;
  assign rs_o         = r_rs;
  assign rt_o         = r_rt;
  assign rd_o         = r_rd;
  assign funct_o      = r_funct;
  assign valid_o      = r_valid;
  assign stall_o      = w_stall;
  assign bubble_cnt_o = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_pipe
// Purpose  : Directed self-checking bench for id_ex_pipe (CW=2 so that the
//            bubble counter saturates quickly).
// Revision : 1.0  initial release
// ============================================================================
module tb_id_ex_pipe;

  localparam int DW = 32;
  localparam int CW = 2;

  // Control codes {RegWrite, ALUSrc, RegDst, Branch, MemRead, MemWrite,
  //                MemtoReg, ALU_op[1:0]}
  localparam logic [8:0] c_CTL_ADDI = 9'b1_1_0_0_0_0_0_01;
  localparam logic [8:0] c_CTL_LW   = 9'b1_1_0_0_1_0_1_00;
  localparam logic [8:0] c_CTL_ADD  = 9'b1_0_1_0_0_0_0_10;
  localparam logic [8:0] c_CTL_SW   = 9'b0_1_0_0_0_1_0_00;
  localparam logic [8:0] c_CTL_NONE = 9'b0;

  localparam logic [31:0] c_ADDI_T0  = 32'h2008_0005; // addi $t0,$zero,5
  localparam logic [31:0] c_LW_T0    = 32'h8D28_0000; // lw   $t0,0($t1)
  localparam logic [31:0] c_ADD_T2   = 32'h010B_5020; // add  $t2,$t0,$t3
  localparam logic [31:0] c_LW_T1    = 32'h8E09_0000; // lw   $t1,0($s0)
  localparam logic [31:0] c_SW_T1    = 32'hAE09_0004; // sw   $t1,4($s0)
  localparam logic [31:0] c_ADDI_T1  = 32'h2209_0001; // addi $t1,$s0,1
  localparam logic [31:0] c_LW_ZERO  = 32'h8D20_0000; // lw   $0,0($t1)
  localparam logic [31:0] c_ADD_ZERO = 32'h0000_5020; // add  $t2,$0,$0

  logic          clk_i;
  logic          rst_i;
  logic [31:0]   instr_i;
  logic [DW-1:0] pc_plus4_i, rs_data_i, rt_data_i, imm_i;
  logic          RegWrite_i, ALUSrc_i, RegDst_i, Branch_i;
  logic          MemRead_i, MemWrite_i, MemtoReg_i;
  logic [1:0]    ALU_op_i;
  logic          flush_i;
  logic          RegWrite_o, ALUSrc_o, RegDst_o, Branch_o;
  logic          MemRead_o, MemWrite_o, MemtoReg_o;
  logic [1:0]    ALU_op_o;
  logic [DW-1:0] pc_plus4_o, rs_data_o, rt_data_o, imm_o;
  logic [4:0]    rs_o, rt_o, rd_o;
  logic [5:0]    funct_o;
  logic          valid_o;
  logic          stall_o;
  logic [CW-1:0] bubble_cnt_o;

  logic [8:0]    w_ctl_o;
  int            n_tests;
  int            n_fail;

  assign w_ctl_o = {RegWrite_o, ALUSrc_o, RegDst_o, Branch_o, MemRead_o,
                    MemWrite_o, MemtoReg_o, ALU_op_o};

  id_ex_pipe #(.DW(DW), .CW(CW)) u_dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .instr_i      (instr_i),
    .pc_plus4_i   (pc_plus4_i),
    .rs_data_i    (rs_data_i),
    .rt_data_i    (rt_data_i),
    .imm_i        (imm_i),
    .RegWrite_i   (RegWrite_i),
    .ALUSrc_i     (ALUSrc_i),
    .RegDst_i     (RegDst_i),
    .Branch_i     (Branch_i),
    .MemRead_i    (MemRead_i),
    .MemWrite_i   (MemWrite_i),
    .MemtoReg_i   (MemtoReg_i),
    .ALU_op_i     (ALU_op_i),
    .flush_i      (flush_i),
    .RegWrite_o   (RegWrite_o),
    .ALUSrc_o     (ALUSrc_o),
    .RegDst_o     (RegDst_o),
    .Branch_o     (Branch_o),
    .MemRead_o    (MemRead_o),
    .MemWrite_o   (MemWrite_o),
    .MemtoReg_o   (MemtoReg_o),
    .ALU_op_o     (ALU_op_o),
    .pc_plus4_o   (pc_plus4_o),
    .rs_data_o    (rs_data_o),
    .rt_data_o    (rt_data_o),
    .imm_o        (imm_o),
    .rs_o         (rs_o),
    .rt_o         (rt_o),
    .rd_o         (rd_o),
    .funct_o      (funct_o),
    .valid_o      (valid_o),
    .stall_o      (stall_o),
    .bubble_cnt_o (bubble_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one ID-stage instruction; operand data derived from the word so
  // captured payloads are distinguishable.
  task automatic drive(input logic [31:0] ins, input logic [8:0] ctl,
                       input logic [DW-1:0] imm, input logic [DW-1:0] pc);
    instr_i    = ins;
    {RegWrite_i, ALUSrc_i, RegDst_i, Branch_i, MemRead_i,
     MemWrite_i, MemtoReg_i, ALU_op_i} = ctl;
    imm_i      = imm;
    pc_plus4_i = pc;
    rs_data_i  = ins ^ 32'hA5A5_0000;
    rt_data_i  = ins ^ 32'h0000_5A5A;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [CW-1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    n_tests = 0;
    n_fail  = 0;
    flush_i = 1'b0;
    rst_i   = 1'b0;
    drive(32'd0, c_CTL_NONE, 32'd0, 32'd0);

    // Reset state
    #22;
    check("rst_ctl",   {55'd0, w_ctl_o}, 64'd0);
    check("rst_valid", {63'd0, valid_o}, 64'd0);
    check("rst_cnt",   {62'd0, bubble_cnt_o}, 64'd0);
    check("rst_stall", {63'd0, stall_o}, 64'd0);
    check("rst_pc",    {32'd0, pc_plus4_o}, 64'd0);
    rst_i = 1'b1;

    // Basic capture: addi $t0,$zero,5
    drive(c_ADDI_T0, c_CTL_ADDI, 32'd5, 32'h0000_0004);
    step();
    check("addi_ctl",   {55'd0, w_ctl_o}, {55'd0, c_CTL_ADDI});
    check("addi_aluop", {62'd0, ALU_op_o}, 64'd1);
    check("addi_rt",    {59'd0, rt_o}, 64'd8);
    check("addi_valid", {63'd0, valid_o}, 64'd1);
    check("addi_stall", {63'd0, stall_o}, 64'd0);
    check("addi_imm",   {32'd0, imm_o}, 64'd5);
    check("addi_pc",    {32'd0, pc_plus4_o}, 64'd4);

    // Load-use on rs
    drive(c_LW_T0, c_CTL_LW, 32'd0, 32'h0000_0008);
    step();
    check("lw_memrd", {63'd0, MemRead_o}, 64'd1);
    drive(c_ADD_T2, c_CTL_ADD, 32'h0000_5020, 32'h0000_000C);
    #1;
    check("rs_stall", {63'd0, stall_o}, 64'd1);
    step();
    check("bub_ctl",   {55'd0, w_ctl_o}, 64'd0);
    check("bub_valid", {63'd0, valid_o}, 64'd0);
    check("bub_cnt",   {62'd0, bubble_cnt_o}, 64'd1);
    check("bub_rs",    {59'd0, rs_o}, 64'd8);
    check("bub_rd",    {59'd0, rd_o}, 64'd10);
    check("bub_stall", {63'd0, stall_o}, 64'd0);
    step();
    check("held_ctl",   {55'd0, w_ctl_o}, {55'd0, c_CTL_ADD});
    check("held_valid", {63'd0, valid_o}, 64'd1);
    check("held_funct", {58'd0, funct_o}, 64'h20);
    check("held_stall", {63'd0, stall_o}, 64'd0);
    check("held_cnt",   {62'd0, bubble_cnt_o}, 64'd1);

    // rt use: sw stalls, addi does not
    drive(c_LW_T1, c_CTL_LW, 32'd0, 32'h0000_0010);
    step();
    drive(c_SW_T1, c_CTL_SW, 32'd4, 32'h0000_0014);
    #1;
    check("sw_stall", {63'd0, stall_o}, 64'd1);
    drive(c_ADDI_T1, c_CTL_ADDI, 32'd1, 32'h0000_0014);
    #1;
    check("addi_rt_nostall", {63'd0, stall_o}, 64'd0);
    step();
    check("addi_rt_valid", {63'd0, valid_o}, 64'd1);
    check("addi_rt_cnt",   {62'd0, bubble_cnt_o}, 64'd1);

    // lw into $0 never stalls
    drive(c_LW_ZERO, c_CTL_LW, 32'd0, 32'h0000_0018);
    step();
    drive(c_ADD_ZERO, c_CTL_ADD, 32'h0000_5020, 32'h0000_001C);
    #1;
    check("zero_nostall", {63'd0, stall_o}, 64'd0);

    // Nop behind a load
    drive(c_LW_T0, c_CTL_LW, 32'd0, 32'h0000_0020);
    step();
    drive(32'd0, c_CTL_NONE, 32'd0, 32'h0000_0024);
    #1;
    check("nop_nostall", {63'd0, stall_o}, 64'd0);
    step();
    check("nop_valid", {63'd0, valid_o}, 64'd0);
    check("nop_cnt",   {62'd0, bubble_cnt_o}, 64'd1);

    // Flush beats hazard
    drive(c_LW_T0, c_CTL_LW, 32'd0, 32'h0000_0028);
    step();
    drive(c_ADD_T2, c_CTL_ADD, 32'h0000_5020, 32'h0000_002C);
    flush_i = 1'b1;
    #1;
    check("flush_stall", {63'd0, stall_o}, 64'd0);
    step();
    flush_i = 1'b0;
    check("flush_ctl",   {55'd0, w_ctl_o}, 64'd0);
    check("flush_valid", {63'd0, valid_o}, 64'd0);
    check("flush_cnt",   {62'd0, bubble_cnt_o}, 64'd1);
    check("flush_rd",    {59'd0, rd_o}, 64'd10);

    // Async reset mid-stall
    drive(c_LW_T0, c_CTL_LW, 32'd0, 32'h0000_0030);
    step();
    drive(c_ADD_T2, c_CTL_ADD, 32'h0000_5020, 32'h0000_0034);
    #1;
    check("ar_stall_pre", {63'd0, stall_o}, 64'd1);
    rst_i = 1'b0;
    #1;
    check("ar_ctl",   {55'd0, w_ctl_o}, 64'd0);
    check("ar_cnt",   {62'd0, bubble_cnt_o}, 64'd0);
    check("ar_valid", {63'd0, valid_o}, 64'd0);
    check("ar_rt",    {59'd0, rt_o}, 64'd0);
    check("ar_stall", {63'd0, stall_o}, 64'd0);
    rst_i = 1'b1;
    step();
    check("ar_post_ctl",   {55'd0, w_ctl_o}, {55'd0, c_CTL_ADD});
    check("ar_post_valid", {63'd0, valid_o}, 64'd1);
    check("ar_post_cnt",   {62'd0, bubble_cnt_o}, 64'd0);

    // Counter saturation with CW=2
    for (int i = 0; i < 5; i++) begin
      drive(c_LW_T0, c_CTL_LW, 32'd0, 32'h0000_0040);
      step();
      drive(c_ADD_T2, c_CTL_ADD, 32'h0000_5020, 32'h0000_0044);
      #1;
      check($sformatf("sat_stall%0d", i), {63'd0, stall_o}, 64'd1);
      step();
      check($sformatf("sat_cnt%0d", i), {62'd0, bubble_cnt_o},
            {62'd0, exp_cnt[i]});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- ID/EX pipeline stage of the 5-stage MIPS CPU, directly downstream of the instruction decoder.
- Registers decoder control signals, register-file operands, the sign-extended immediate, PC+4 and register-field indices into the EX stage.
- Contains load-use hazard detection: stalls PC and IF/ID and inserts a bubble into EX.
- Accepts a branch flush from the MEM stage.
- Keeps a saturating count of inserted stall bubbles.

Parameters:
- DW, 32, datapath width for operands, immediate and PC+4.
- CW, 16, bubble-counter width.

Ports:
- clk_i  input  1  system clock, rising-edge.
- rst_i  input  1  asynchronous active-low reset.
- instr_i  input  32  IF/ID instruction word (fields rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0], op=[31:26]).
- pc_plus4_i  input  DW  IF/ID PC+4.
- rs_data_i  input  DW  register-file read data 1.
- rt_data_i  input  DW  register-file read data 2.
- imm_i  input  DW  sign-extended immediate.
- RegWrite_i, ALUSrc_i, RegDst_i, Branch_i, MemRead_i, MemWrite_i, MemtoReg_i  input  1 each  decoder controls.
- ALU_op_i  input  2  decoder ALU op.
- flush_i  input  1  branch taken in MEM; kill the ID instruction.
- RegWrite_o, ALUSrc_o, RegDst_o, Branch_o, MemRead_o, MemWrite_o, MemtoReg_o  output  1 each  registered controls.
- ALU_op_o  output  2  registered ALU op.
- pc_plus4_o, rs_data_o, rt_data_o, imm_o  output  DW  registered data.
- rs_o, rt_o, rd_o  output  5 each  registered register indices.
- funct_o  output  6  registered funct field.
- valid_o  output  1  EX holds a real, non-bubble, non-nop instruction.
- stall_o  output  1  combinational; hold PC and IF/ID this cycle.
- bubble_cnt_o  output  CW  number of load-use bubbles inserted.

Behaviour:
- Reset (rst_i low, asynchronous): every registered output goes to 0, including valid_o and bubble_cnt_o. stall_o evaluates to 0 because MemRead_o=0.
- Latency: one cycle. On each rising edge the inputs are captured and appear on the outputs.

Hazard detection (combinational, from current outputs and instr_i):
- Let uses_rt = 1 when op is 0 (R-type), 4 (beq) or 43 (sw).
- hazard = MemRead_o & (rt_o != 0) & (instr_i != 0) & ((rt_o == instr_i[25:21]) | (uses_rt & (rt_o == instr_i[20:16]))).
- stall_o = hazard & ~flush_i.

Edge priority (highest first):
- flush_i = 1:
  - All control outputs and valid_o are loaded with 0.
  - Data and index fields are still captured.
  - bubble_cnt_o is unchanged.
- stall_o = 1:
  - All control outputs and valid_o are loaded with 0 (bubble).
  - Data and index fields are still captured; they are don't-care downstream, but the bench checks them for determinism.
  - bubble_cnt_o increments by 1 and saturates at all-ones; it does not wrap.
- Otherwise:
  - All fields are captured.
  - valid_o = (instr_i != 0).

Boundary rules:
- Nop (instr_i = 0): no hazard check; controls from the decoder are all 0 and are captured as-is.
- A load into $0 (rt_o = 0) never stalls.
- A load followed by an instruction using only rs: only the rs match is checked. For addi/slti/lw, a match on rt is a destination, not a hazard.
- Back-to-back loads with a dependency: one bubble only. After the bubble, MemRead_o=0, so the held instruction proceeds next cycle.
- Simultaneous flush_i and hazard: flush wins, stall_o=0, no count.
- Reset asserted mid-stall: outputs clear immediately, independent of the clock. After release the first edge behaves normally.

Test Plan:
- Reset, then release: all outputs are 0. Apply addi $t0,$zero,5 (0x20080005) with RegWrite_i=1, ALU_op_i=01, ALUSrc_i=1. Next edge: RegWrite_o=1, ALU_op_o=01, rt_o=8, valid_o=1, stall_o=0.
- Load-use on rs: EX holds lw $t0,0($t1) (MemRead_o=1, rt_o=8); ID holds add $t2,$t0,$t3.
  - Required: stall_o=1, and the next edge gives all controls 0, valid_o=0, bubble_cnt_o=1.
  - The edge after that captures the add with valid_o=1 and stall_o=0.
- Load-use on rt for sw versus addi: EX is a lw with rt=9.
  - ID sw $t1,4($s0) (rt=9): stall_o=1.
  - ID addi $t1,$s0,1: stall_o=0.
- Guard conditions:
  - lw into $0 followed by add using $0: stall_o=0.
  - instr_i=0 with a matching lw in EX: stall_o=0, valid_o=0 after the edge.
- Flush priority: hazard present and flush_i=1 in the same cycle.
  - Required: stall_o=0, the next edge gives all controls 0, and bubble_cnt_o is unchanged.
  - With CW=2, force 5 stalls: bubble_cnt_o reads 1, 2, 3, 3, 3.
- Async reset during a stall: drop rst_i between edges. All outputs are 0 within the same cycle, and bubble_cnt_o is 0.
